// File: rtl/win_div_32_16_signed.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor -> 16-bit quotient and remainder.
// Radix-2 restoring division on magnitudes, one quotient bit per clock, start/busy/done handshake.
`timescale 1ns/1ps
module win_div_32_16_signed #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] div_a,
    input  logic [15:0] div_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);
    localparam int DATA_W = 32;
    localparam int COEF_W = 16;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t              state;
    logic [4:0]          iter;
    logic                sign_q;
    logic                sign_r;
    logic                zero_div;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   quo_mag;
    logic [COEF_W:0]     mag_b;
    logic [COEF_W:0]     part_rem;
    logic [COEF_W:0]     shifted;
    logic [COEF_W:0]     diff;
    logic                fits;
    logic [COEF_W-1:0]   q_next;
    logic [COEF_W-1:0]   r_next;
    logic                ov_next;

    // |a| as unsigned: 0x80000000 maps to 2^31, which still fits in 32 bits.
    function automatic logic [DATA_W-1:0] abs_dividend(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] neg;
        neg = DATA_W'(-v);
        return v[DATA_W-1] ? neg : DATA_W'(v);
    endfunction

    function automatic logic [COEF_W:0] abs_divisor(input logic signed [COEF_W-1:0] v);
        logic signed [COEF_W:0] ext;
        ext = {v[COEF_W-1], v};
        return ext[COEF_W] ? (COEF_W+1)'(-ext) : (COEF_W+1)'(ext);
    endfunction

    function automatic logic out_of_range(input logic [DATA_W-1:0] mag, input logic neg);
        return neg ? (mag > 32'd32768) : (mag > 32'd32767);
    endfunction

    // Signed quotient, clamped to the 16-bit range when saturation is enabled.
    function automatic logic [COEF_W-1:0] sat_quotient(input logic [DATA_W-1:0] mag,
                                                       input logic neg);
        logic [DATA_W-1:0] signed_q;
        signed_q = neg ? DATA_W'(-mag) : mag;
        if (SATURATE && out_of_range(mag, neg))
            return neg ? 16'h8000 : 16'h7FFF;
        return signed_q[COEF_W-1:0];
    endfunction

    function automatic logic [COEF_W-1:0] signed_remainder(input logic [COEF_W:0] mag,
                                                           input logic neg);
        logic [COEF_W-1:0] low;
        low = mag[COEF_W-1:0];
        return neg ? COEF_W'(-low) : low;
    endfunction

    always_comb begin
        shifted = {part_rem[COEF_W-1:0], mag_a[DATA_W-1]};
        fits    = (shifted >= mag_b);
        diff    = shifted - mag_b;
        if (zero_div) begin
            q_next  = sign_r ? 16'h8000 : 16'h7FFF;
            r_next  = '0;
            ov_next = 1'b0;
        end else begin
            q_next  = sat_quotient(quo_mag, sign_q);
            r_next  = signed_remainder(part_rem, sign_r);
            ov_next = out_of_range(quo_mag, sign_q);
        end
    end

    // Datapath: operands captured on accept, one restoring step per CALC cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            sign_q   <= div_a[DATA_W-1] ^ div_b[COEF_W-1];
            sign_r   <= div_a[DATA_W-1];
            zero_div <= (div_b == '0);
            mag_a    <= abs_dividend(div_a);
            mag_b    <= abs_divisor(div_b);
            part_rem <= '0;
            quo_mag  <= '0;
        end else if (state == CALC) begin
            mag_a    <= {mag_a[DATA_W-2:0], 1'b0};
            part_rem <= fits ? diff : shifted;
            quo_mag  <= {quo_mag[DATA_W-2:0], fits};
        end
    end

    // Control and registered outputs; results only change at the FIN->IDLE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            iter        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC;
                        iter  <= '0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    iter <= iter + 5'd1;
                    if (iter == 5'd31)
                        state <= FIN;
                end
                FIN: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= q_next;
                    remainder   <= r_next;
                    div_by_zero <= zero_div;
                    overflow    <= ov_next;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/win_div_32_16_signed.md
Name: win_div_32_16_signed

Overview:
Sequential signed divider. Divides a 32-bit two's-complement dividend by a 16-bit two's-complement divisor and returns a 16-bit quotient and a 16-bit remainder. It is the inverse of the 16x16 signed multiplier in the Winograd datapath and is used to rescale and normalise accumulated 32-bit products back to 16-bit fixed point. It uses a radix-2 restoring algorithm on magnitudes, one quotient bit per clock, with a start/busy/done handshake.

Parameters:
SATURATE, 1, 1 = clamp an out-of-range quotient to 0x7FFF/0x8000; 0 = output the low 16 bits of the true quotient.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
div_a  input  32  dividend, two's complement; sampled with start
div_b  input  16  divisor, two's complement; sampled with start
busy  output  1  high from the accepting edge until done
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  16  two's complement, held until next done
remainder  output  16  two's complement, held until next done
div_by_zero  output  1  divisor was 0; held with results
overflow  output  1  quotient magnitude out of 16-bit range; held with results

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
- Reset state: state=IDLE; busy, done, quotient, remainder, div_by_zero and overflow all 0. Reset mid-operation aborts the division; no done pulse is produced.
- States: IDLE, CALC, FIN.
- IDLE to CALC when start=1. At that edge:
  - register sign_q = a[31]^b[15] and sign_r = a[31];
  - register |a| as a 32-bit unsigned value (0x80000000 stays valid) and |b| as a 17-bit value;
  - clear the partial remainder (17 bits) and the iteration counter; set busy=1.
- CALC, 32 cycles, MSB first, each cycle:
  - shift the partial remainder left and bring in the next |a| bit;
  - if the result is >= |b|, subtract |b| and shift in a quotient bit of 1, else shift in 0.
  - The quotient register is 32 bits. After iteration 31, go to FIN.
- FIN, 1 cycle, then IDLE. At the FIN to IDLE edge:
  - load the outputs, pulse done=1 for one cycle, clear busy;
  - start seen at this same edge is ignored, so a new start is accepted from the next cycle.
- Latency: start accepted at edge N gives the results and done in the cycle after edge N+33. busy is high for 33 cycles.
- start while busy=1 is ignored, and inputs are not resampled.
- Sign rules: truncation toward zero. Quotient sign is sign_q; remainder sign is sign_r. A zero magnitude is output as 0 regardless of sign.
- Overflow: set when the quotient magnitude exceeds 32767 with sign_q=0, or exceeds 32768 with sign_q=1.
  - SATURATE=1: quotient is 0x7FFF (sign_q=0) or 0x8000 (sign_q=1).
  - Remainder is always exact; |r| < |b| <= 32768, so it fits in 16 bits.
- Divide by zero (b==0):
  - fixed latency is preserved;
  - div_by_zero=1, overflow=0, remainder=0;
  - quotient is 0x7FFF if a>=0, else 0x8000, independent of SATURATE.
- Zero dividend: quotient=0, remainder=0, no flags.
- Outputs are registered only and change only at the done edge or at reset.

Test Plan:
- a=100, b=7, start for 1 cycle -> busy high for 33 cycles, done 34 cycles after start; quotient=14 (0x000E), remainder=2, flags 0.
- Sign matrix:
  - a=-100, b=7 -> q=0xFFF2, r=0xFFFE;
  - a=100, b=-7 -> q=0xFFF2, r=0x0002;
  - a=-100, b=-7 -> q=0x000E, r=0xFFFE.
- Range edges:
  - a=0xFFFF8000 (-32768), b=1 -> q=0x8000, overflow=0;
  - a=32768, b=1 -> q=0x7FFF, overflow=1;
  - a=0x80000000, b=-32768 -> q=0x7FFF (true 65536), overflow=1, r=0;
  - SATURATE=0, a=32768, b=1 -> q=0x8000, overflow=1.
- Divide by zero:
  - a=5, b=0 -> q=0x7FFF, r=0, div_by_zero=1;
  - a=-5, b=0 -> q=0x8000;
  - a following valid division -> flag clears.
- Handshake:
  - start pulsed again at cycle 5 of a busy operation with different operands -> ignored, first result unchanged;
  - start held high continuously -> back-to-back results every 34 cycles.
- Reset mid-CALC at iteration 10 -> all outputs 0 immediately (asynchronous), no done pulse; a fresh start afterwards gives correct results (a=1000, b=-33 -> q=0xFFE2 (-30), r=10).
